// File: rtl/decode_stage_pkg.sv
// -----------------------------------------------------------------------------
// decode_stage_pkg
// Shared constants for the instruction-decode stage: opcode values, the
// legal-opcode list, FSM state encodings, instruction field positions and the
// decoded-field bundle passed between decode_fields and decode_stage.
// Optional build macro: DECODE_ILLEGAL_EN (uses opcode_legal below).
// -----------------------------------------------------------------------------
package decode_stage_pkg;

    // Short (single-word) opcodes. Bit 7 set marks the two-word variant.
    localparam logic [7:0] OPC_NOP     = 8'h00;
    localparam logic [7:0] OPC_ADD     = 8'h01;
    localparam logic [7:0] OPC_SUB     = 8'h02;
    localparam logic [7:0] OPC_AND     = 8'h03;
    localparam logic [7:0] OPC_OR      = 8'h04;
    localparam logic [7:0] OPC_XOR     = 8'h05;
    localparam logic [7:0] OPC_MOV     = 8'h06;
    localparam logic [7:0] OPC_LD      = 8'h10;
    localparam logic [7:0] OPC_ST      = 8'h11;
    localparam logic [7:0] OPC_PUSH    = 8'h12;
    localparam logic [7:0] OPC_POP     = 8'h13;
    localparam logic [7:0] OPC_JMP     = 8'h20;
    localparam logic [7:0] OPC_SET     = 8'h21;
    // MOVB Rn, #imm8: one opcode per destination register, consecutive.
    localparam logic [7:0] OPC_MOVB_R0 = 8'h30;
    localparam logic [7:0] OPC_MOVB_R7 = 8'h37;
    // Two-word opcodes with dedicated decode behaviour.
    localparam logic [7:0] OPC_LDI     = 8'h90;
    localparam logic [7:0] OPC_STI     = 8'h91;
    localparam logic [7:0] OPC_PUSHI   = 8'h92;
    localparam logic [7:0] OPC_JMPI    = 8'hA0;

    // Field positions inside an opcode word.
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 8;
    localparam int RD_MSB   = 2;
    localparam int RD_LSB   = 0;
    localparam int RS_MSB   = 5;
    localparam int RS_LSB   = 3;
    localparam int MEMB_BIT = 7;
    localparam int DISP_BIT = 6;
    localparam int COND_MSB = 6;
    localparam int COND_LSB = 3;
    localparam int IMM8_MSB = 7;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] alu_control;
        logic [2:0] rd_sel;
        logic [2:0] rs_sel;
        logic       en_immediate;
        logic       two_word;
        logic       en_mem;
        logic       mem_byte;
        logic       mem_displacement;
        logic [3:0] condition;
    } fields_t;

    // Legal-opcode list: the short opcodes the core implements.
    function automatic logic opcode_listed(input logic [7:0] opc);
        case (opc)
            OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_MOV,
            OPC_LD, OPC_ST, OPC_PUSH, OPC_POP, OPC_JMP, OPC_SET: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Listed opcodes, their bit-7 (two-word) variants and MOVB are legal.
    function automatic logic opcode_legal(input logic [7:0] opc);
        return opcode_listed(opc)
            || (opc[7] && opcode_listed({1'b0, opc[6:0]}))
            || ((opc >= OPC_MOVB_R0) && (opc <= OPC_MOVB_R7));
    endfunction

endpackage

// File: rtl/decode_stage_fields.sv
// -----------------------------------------------------------------------------
// decode_fields
// Purely combinational decode of one opcode word into instruction fields.
// Used both for single-word instructions and for the first word of a
// two-word instruction that gets staged until its immediate arrives.
// Ports:
//   word    in   DATA_W  opcode word (bits above 15 ignored)
//   fields  out  bundle  decoded fields
//   imm     out  DATA_W  MOVB immediate, zero for everything else
//   illegal out  1       undefined opcode (only with DECODE_ILLEGAL_EN)
// -----------------------------------------------------------------------------
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SP_REG    = 7,
    parameter int MOVB_SEXT = 0
) (
    input  logic [DATA_W-1:0] word,
    output fields_t           fields,
    output logic [DATA_W-1:0] imm
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    logic [7:0] opc;
    logic       is_movb;

    assign opc     = word[OPC_MSB:OPC_LSB];
    assign is_movb = (opc >= OPC_MOVB_R0) && (opc <= OPC_MOVB_R7);

    // Wide words carry nothing useful above bit 15 in an opcode word.
    if (DATA_W > 16) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^word[DATA_W-1:16];
    end

    always_comb begin
        fields = '0;
        imm    = '0;

        fields.alu_control  = {1'b0, opc[6:0]};
        fields.rd_sel       = word[RD_MSB:RD_LSB];
        fields.en_immediate = opc[7];
        fields.two_word     = opc[7];

        if ((opc == OPC_PUSH) || (opc == OPC_POP) || (opc == OPC_PUSHI)) begin
            fields.rs_sel = 3'(SP_REG);
        end else begin
            fields.rs_sel = word[RS_MSB:RS_LSB];
        end

        case (opc)
            OPC_ST, OPC_LD, OPC_LDI, OPC_STI, OPC_PUSH, OPC_PUSHI, OPC_POP: begin
                fields.en_mem   = 1'b1;
                fields.mem_byte = word[MEMB_BIT];
            end
            default: ;
        endcase

        if ((opc == OPC_LDI) || (opc == OPC_STI)) begin
            fields.mem_displacement = word[DISP_BIT];
        end

        if ((opc == OPC_JMP) || (opc == OPC_JMPI) || (opc == OPC_SET)) begin
            fields.condition = word[COND_MSB:COND_LSB];
        end

        // MOVB carries its 8-bit immediate in the opcode word itself.
        if (is_movb) begin
            fields.alu_control  = OPC_MOV;
            fields.rd_sel       = opc[2:0];
            fields.en_immediate = 1'b1;
            fields.two_word     = 1'b0;
            if (MOVB_SEXT != 0) begin
                imm = {{(DATA_W-8){word[IMM8_MSB]}}, word[IMM8_MSB:0]};
            end else begin
                imm = {{(DATA_W-8){1'b0}}, word[IMM8_MSB:0]};
            end
        end

`ifdef DECODE_ILLEGAL_EN
        illegal = 1'b0;
        // An undefined opcode becomes a harmless single-word NOP.
        if (!opcode_legal(opc)) begin
            illegal             = 1'b1;
            fields.alu_control  = OPC_NOP;
            fields.en_mem       = 1'b0;
            fields.mem_byte     = 1'b0;
            fields.two_word     = 1'b0;
            fields.en_immediate = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Handshaked instruction-decode stage between fetch and register-read/ALU.
// Assembles two-word (opcode + immediate) instructions and emits one decoded
// instruction per output transfer. Optional build macro DECODE_ILLEGAL_EN adds
// the illegal output and turns undefined opcodes into single-word NOPs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop any partial or held instruction
//   in_valid/in_ready     input word handshake, in_word is the word
//   out_valid/out_ready   decoded instruction handshake
//   alu_control, rD_sel, rS_sel, immediate, en_immediate, two_word,
//   en_mem, mem_byte, mem_displacement, condition, illegal  decoded fields
// -----------------------------------------------------------------------------
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int SP_REG    = 7,
    parameter int MOVB_SEXT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        alu_control,
    output logic [2:0]        rD_sel,
    output logic [2:0]        rS_sel,
    output logic [DATA_W-1:0] immediate,
    output logic              en_immediate,
    output logic              two_word,
    output logic              en_mem,
    output logic              mem_byte,
    output logic              mem_displacement,
    output logic [3:0]        condition
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic              illegal
`endif
);

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    fields_t           out_q, out_d;
    fields_t           stage_q, stage_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    fields_t           dec;
    logic [DATA_W-1:0] dec_imm;
    logic              in_xfer;
    logic              out_xfer;

`ifdef DECODE_ILLEGAL_EN
    logic              illegal_q, illegal_d;
    logic              dec_illegal;
`endif

    decode_fields #(
        .DATA_W    (DATA_W),
        .SP_REG    (SP_REG),
        .MOVB_SEXT (MOVB_SEXT)
    ) u_fields (
        .word    (in_word),
        .fields  (dec),
        .imm     (dec_imm)
`ifdef DECODE_ILLEGAL_EN
        ,
        .illegal (dec_illegal)
`endif
    );

    // Same rule in both states: a word may enter only when the output slot
    // is free or being drained this cycle.
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        stage_d     = stage_q;
        imm_d       = imm_q;
`ifdef DECODE_ILLEGAL_EN
        illegal_d   = illegal_q;
`endif

        if (flush) begin
            state_d     = S_OP;
            out_valid_d = 1'b0;
        end else begin
            if (out_xfer) begin
                out_valid_d = 1'b0;
            end
            if (in_xfer) begin
                if (state_q == S_OP) begin
                    if (dec.two_word) begin
                        // First half only: the output slot is left alone.
                        stage_d = dec;
                        state_d = S_IMM;
                    end else begin
                        out_d       = dec;
                        imm_d       = dec_imm;
                        out_valid_d = 1'b1;
`ifdef DECODE_ILLEGAL_EN
                        illegal_d   = dec_illegal;
`endif
                    end
                end else begin
                    out_d       = stage_q;
                    imm_d       = in_word;
                    out_valid_d = 1'b1;
                    state_d     = S_OP;
`ifdef DECODE_ILLEGAL_EN
                    illegal_d   = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OP;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            stage_q     <= '0;
            imm_q       <= '0;
`ifdef DECODE_ILLEGAL_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            stage_q     <= stage_d;
            imm_q       <= imm_d;
`ifdef DECODE_ILLEGAL_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign out_valid        = out_valid_q;
    assign alu_control      = out_q.alu_control;
    assign rD_sel           = out_q.rd_sel;
    assign rS_sel           = out_q.rs_sel;
    assign immediate        = imm_q;
    assign en_immediate     = out_q.en_immediate;
    assign two_word         = out_q.two_word;
    assign en_mem           = out_q.en_mem;
    assign mem_byte         = out_q.mem_byte;
    assign mem_displacement = out_q.mem_displacement;
    assign condition        = out_q.condition;
`ifdef DECODE_ILLEGAL_EN
    assign illegal          = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage (DATA_W 16, SP_REG 7). A second instance
// with MOVB_SEXT = 1 shares the inputs to cover the sign-extended MOVB form.
// Expected decodes are queued when words are driven and compared when the
// main instance hands out a decoded instruction.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_word;
    logic        out_ready;

    logic        in_ready, out_valid, en_immediate, two_word, en_mem, mem_byte, mem_displacement;
    logic [7:0]  alu_control;
    logic [2:0]  rD_sel, rS_sel;
    logic [15:0] immediate;
    logic [3:0]  condition;

    logic        sx_in_ready, sx_out_valid, sx_en_immediate, sx_two_word, sx_en_mem, sx_mem_byte, sx_mem_disp;
    logic [7:0]  sx_alu_control;
    logic [2:0]  sx_rD_sel, sx_rS_sel;
    logic [15:0] sx_immediate;
    logic [3:0]  sx_condition;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal, sx_illegal;
`endif

    decode_stage #(.DATA_W(16), .SP_REG(7), .MOVB_SEXT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .rD_sel(rD_sel), .rS_sel(rS_sel),
        .immediate(immediate), .en_immediate(en_immediate), .two_word(two_word),
        .en_mem(en_mem), .mem_byte(mem_byte), .mem_displacement(mem_displacement),
        .condition(condition)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    decode_stage #(.DATA_W(16), .SP_REG(7), .MOVB_SEXT(1)) dut_sx (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(sx_in_ready), .in_word(in_word),
        .out_valid(sx_out_valid), .out_ready(out_ready),
        .alu_control(sx_alu_control), .rD_sel(sx_rD_sel), .rS_sel(sx_rS_sel),
        .immediate(sx_immediate), .en_immediate(sx_en_immediate), .two_word(sx_two_word),
        .en_mem(sx_en_mem), .mem_byte(sx_mem_byte), .mem_displacement(sx_mem_disp),
        .condition(sx_condition)
`ifdef DECODE_ILLEGAL_EN
        , .illegal(sx_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  alu;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        rs_dc;
        logic [15:0] imm;
        logic        en_imm;
        logic        two;
        logic        en_mem;
        logic        mb;
        logic        disp;
        logic [3:0]  cond;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic last_acc;
    logic last_rdy;
    int   last_ticks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [7:0] alu, input logic [2:0] rd, input logic [2:0] rs,
                            input logic rs_dc, input logic [15:0] imm, input logic en_imm,
                            input logic two, input logic em, input logic mb, input logic disp,
                            input logic [3:0] cond, input logic ill);
        exp_t e;
        e.alu = alu; e.rd = rd; e.rs = rs; e.rs_dc = rs_dc; e.imm = imm;
        e.en_imm = en_imm; e.two = two; e.en_mem = em; e.mb = mb; e.disp = disp;
        e.cond = cond; e.ill = ill;
        sbq.push_back(e);
    endtask

    // One clock: sample just after the falling edge, score any output
    // transfer, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        last_rdy = in_ready;
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready && !flush) begin
            chk("sb_pending", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("alu_control", alu_control, e.alu);
                chk("rD_sel", rD_sel, e.rd);
                if (!e.rs_dc) chk("rS_sel", rS_sel, e.rs);
                chk("immediate", immediate, e.imm);
                chk("en_immediate", en_immediate, e.en_imm);
                chk("two_word", two_word, e.two);
                chk("en_mem", en_mem, e.en_mem);
                chk("mem_byte", mem_byte, e.mb);
                chk("mem_displacement", mem_displacement, e.disp);
                chk("condition", condition, e.cond);
`ifdef DECODE_ILLEGAL_EN
                chk("illegal", illegal, e.ill);
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] w);
        in_valid   = 1'b1;
        in_word    = w;
        last_ticks = 0;
        do begin
            tick();
            last_ticks++;
        end while (!last_acc && last_ticks < 20);
        if (!last_acc) chk("send_timeout", last_acc, 1'b1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = 16'h0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_alu", alu_control, 8'h00);
        chk("rst_imm", immediate, 16'h0);
        chk("rst_two_word", two_word, 1'b0);
        chk("rst_rd", rD_sel, 3'd0);
        rst_n = 1'b1;
        tick();

        // MOVB R5, #0xF0
        push_exp(8'h06, 3'd5, 3'd0, 1'b1, 16'h00F0, 1, 0, 0, 0, 0, 4'h0, 0);
        send(16'h35F0); idle();
        chk("movb_latency", out_valid, 1'b1);
        chk("movb_sext_valid", sx_out_valid, 1'b1);
        chk("movb_sext_imm", sx_immediate, 16'hFFF0);
        chk("movb_sext_rd", sx_rD_sel, 3'd5);
        tick();
        chk("drain_clears_valid", out_valid, 1'b0);

        // PUSHI with immediate 0x1234, no gap between the two words
        push_exp(8'h12, 3'd1, 3'd7, 1'b0, 16'h1234, 1, 1, 1, 1, 0, 4'h0, 0);
        send(16'h92C1);
        chk("first_word_no_out", out_valid, 1'b0);
        send(16'h1234); idle();
        chk("pushi_latency", out_valid, 1'b1);
        tick();

        // LDI displacement then JMPI with condition, back to back
        push_exp(8'h10, 3'd0, 3'd1, 1'b0, 16'hBEEF, 1, 1, 1, 0, 1, 4'h0, 0);
        send(16'h9048); send(16'hBEEF);
        push_exp(8'h20, 3'd2, 3'd3, 1'b0, 16'h0042, 1, 1, 0, 0, 0, 4'hB, 0);
        send(16'hA05A); send(16'h0042); idle();
        tick(); tick();

        // Asynchronous reset while waiting for an immediate word
        send(16'h9012); idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_alu", alu_control, 8'h00);
        chk("midrst_imm", immediate, 16'h0);
        chk("midrst_cond", condition, 4'h0);
        chk("midrst_en_imm", en_immediate, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(8'h00, 3'd2, 3'd2, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h0012); idle();
        chk("post_rst_short_latency", out_valid, 1'b1);
        tick();

        // ST byte and SET with condition
        push_exp(8'h11, 3'd5, 3'd0, 1'b0, 16'h0000, 0, 0, 1, 1, 0, 4'h0, 0);
        send(16'h1185);
        push_exp(8'h21, 3'd0, 3'd7, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'hF, 0);
        send(16'h2178); idle();
        tick();

        // Backpressure: consumer stalls for three cycles
        out_ready = 1'b0;
        push_exp(8'h01, 3'd2, 3'd1, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h010A);
        push_exp(8'h02, 3'd3, 3'd2, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        in_valid = 1'b1; in_word = 16'h0213;
        repeat (3) begin
            tick();
            chk("bp_in_ready", last_rdy, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_alu_stable", alu_control, 8'h01);
            chk("bp_rd_stable", rD_sel, 3'd2);
        end
        out_ready = 1'b1;
        send(16'h0213);
        chk("stream_1", last_ticks, 1);
        push_exp(8'h03, 3'd4, 3'd4, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h0324);
        chk("stream_2", last_ticks, 1);
        push_exp(8'h04, 3'd5, 3'd6, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h0435);
        chk("stream_3", last_ticks, 1);
        idle();
        tick();

        // Flush while waiting for an immediate word
        send(16'h8107);
        in_valid = 1'b1; in_word = 16'h0653; flush = 1'b1;
        tick();
        chk("flush_imm_in_ready", last_rdy, 1'b0);
        flush = 1'b0;
        push_exp(8'h06, 3'd3, 3'd2, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h0653); idle();
        chk("flush_next_is_opcode", out_valid, 1'b1);
        tick();

        // Flush while a decoded instruction is on offer
        send(16'h0001); idle();
        chk("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        tick();
        chk("flush_out_in_ready", last_rdy, 1'b0);
        flush = 1'b0;
        chk("flush_clears_valid", out_valid, 1'b0);
        push_exp(8'h05, 3'd7, 3'd7, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h05FF); idle();
        tick();

`ifdef DECODE_ILLEGAL_EN
        // Unlisted opcode with bit 7 set stays single-word
        push_exp(8'h00, 3'd5, 3'd2, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 1);
        send(16'hFF55); idle();
        chk("illegal_latency", out_valid, 1'b1);
        tick();
        push_exp(8'h00, 3'd2, 3'd2, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 4'h0, 0);
        send(16'h0012); idle();
        chk("after_illegal_short", out_valid, 1'b1);
        tick();
`endif

        repeat (2) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        chk("final_out_valid", out_valid, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
